// File: rtl/uart_print_pkg.sv
// ---------------------------------------------------------------------------
// uart_print_pkg
//   Shared definitions for the UART print arbiter:
//     - FSM state encoding (IDLE / XFER)
//     - byte width of the UART data path
//     - default stall-watchdog timeout derived from the 27 MHz system clock
// ---------------------------------------------------------------------------
package uart_print_pkg;

    // Width of one UART character.
    localparam int BYTE_W = 8;

    // System clock and watchdog window used to derive the default timeout.
    localparam int SYS_CLK_HZ       = 27_000_000;
    localparam int PRINT_TIMEOUT_MS = 100;

    // 100 ms of silence mid-message at 27 MHz = 2_700_000 cycles.
    localparam int DEF_TIMEOUT_CYC  = (SYS_CLK_HZ / 1000) * PRINT_TIMEOUT_MS;

    // Arbiter state: IDLE picks the next owner, XFER streams its message.
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_XFER = 1'b1
    } state_e;

endpackage : uart_print_pkg

// File: rtl/uart_print_arbiter_rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick
//   Combinational round-robin selector. Starting at (I_ptr + 1) mod N_REQ and
//   wrapping upward, it returns the first requester whose request bit is set.
//   The requester at I_ptr itself is considered last, so the most recent
//   winner has the lowest priority.
//
// Ports:
//   I_req   [N_REQ-1:0] : request vector
//   I_ptr   [ID_W-1:0]  : index of the previous winner
//   O_win   [N_REQ-1:0] : one-hot winner (all zero when no request)
//   O_idx   [ID_W-1:0]  : index of the winner (zero when no request)
//   O_any               : at least one request is pending
// ---------------------------------------------------------------------------
module rr_pick
    import uart_print_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2
) (
    input  logic [N_REQ-1:0] I_req,
    input  logic [ID_W-1:0]  I_ptr,
    output logic [N_REQ-1:0] O_win,
    output logic [ID_W-1:0]  O_idx,
    output logic             O_any
);

    logic            found_s;
    logic [ID_W-1:0] cand_s;

    // Walk the candidates in priority order and keep the first one that requests.
    always_comb begin
        O_win   = '0;
        O_idx   = '0;
        found_s = 1'b0;
        cand_s  = '0;
        for (int i = 1; i <= N_REQ; i++) begin
            // Candidate index wraps modulo N_REQ, which also covers non-power-of-2 counts.
            cand_s = ID_W'((int'(I_ptr) + i) % N_REQ);
            if (!found_s && I_req[cand_s]) begin
                found_s       = 1'b1;
                O_win[cand_s] = 1'b1;
                O_idx         = cand_s;
            end else begin
                found_s = found_s;
            end
        end
    end

    assign O_any = |I_req;

endmodule : rr_pick

// File: rtl/uart_print_arbiter.sv
// ---------------------------------------------------------------------------
// uart_print_arbiter
//   Shares one UART byte transmitter among N_REQ print requesters.
//   A round-robin pick in IDLE selects an owner; the owner then keeps the
//   transmitter (XFER) until its byte flagged "last" is accepted. A stall
//   watchdog aborts the message if the owner stays silent for TIMEOUT_CYC
//   cycles. A one-entry output register decouples the serializer; it is
//   refilled in the same cycle it drains, so throughput is one byte/cycle.
//
// Ports:
//   I_clk, I_rst          : clock, asynchronous active-high reset
//   I_req_valid/last      : per-requester byte valid / end-of-message flag
//   I_req_data            : requester k byte at bits [8k+7:8k]
//   O_req_ready           : per-requester accept (only the owner, in XFER)
//   O_tx_valid/O_tx_data  : byte toward the UART serializer
//   I_tx_ready            : serializer can take a byte
//   O_grant               : one-hot owner, zero in IDLE
//   O_busy                : high while in XFER
//   O_abort/O_abort_id    : one-cycle abort pulse / index of aborted owner
//   O_msg_cnt             : completed-message counter (wraps)
// ---------------------------------------------------------------------------
module uart_print_arbiter
    import uart_print_pkg::*;
#(
    parameter int N_REQ       = 4,
    parameter int ID_W        = 2,
    parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC,
    parameter int TO_W        = 22,
    parameter int CNT_W       = 16
) (
    input  logic                    I_clk,
    input  logic                    I_rst,
    input  logic [N_REQ-1:0]        I_req_valid,
    input  logic [BYTE_W*N_REQ-1:0] I_req_data,
    input  logic [N_REQ-1:0]        I_req_last,
    output logic [N_REQ-1:0]        O_req_ready,
    output logic                    O_tx_valid,
    output logic [BYTE_W-1:0]       O_tx_data,
    input  logic                    I_tx_ready,
    output logic [N_REQ-1:0]        O_grant,
    output logic                    O_busy,
    output logic                    O_abort,
    output logic [ID_W-1:0]         O_abort_id,
    output logic [CNT_W-1:0]        O_msg_cnt
);

    // -----------------------------------------------------------------------
    // State and datapath registers
    // -----------------------------------------------------------------------
    state_e              state_q,    state_d;
    logic [N_REQ-1:0]    grant_q,    grant_d;
    logic [ID_W-1:0]     gidx_q,     gidx_d;      // index form of grant_q
    logic [ID_W-1:0]     ptr_q,      ptr_d;       // last round-robin winner
    logic                tx_valid_q, tx_valid_d;
    logic [BYTE_W-1:0]   tx_data_q,  tx_data_d;
    logic                abort_q,    abort_d;
    logic [ID_W-1:0]     abort_id_q, abort_id_d;
    logic [CNT_W-1:0]    msg_cnt_q,  msg_cnt_d;
    logic [TO_W-1:0]     to_cnt_q,   to_cnt_d;

    // -----------------------------------------------------------------------
    // Combinational helpers
    // -----------------------------------------------------------------------
    logic [N_REQ-1:0]    pick_win_s;
    logic [ID_W-1:0]     pick_idx_s;
    logic                pick_any_s;
    logic                own_valid_s;
    logic                own_last_s;
    logic [BYTE_W-1:0]   own_data_s;
    logic                out_free_s;
    logic                accept_s;
    logic [N_REQ-1:0]    req_ready_s;

    rr_pick #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_rr_pick (
        .I_req (I_req_valid),
        .I_ptr (ptr_q),
        .O_win (pick_win_s),
        .O_idx (pick_idx_s),
        .O_any (pick_any_s)
    );

    // Owner-side view of the requester bus and the byte handshake.
    always_comb begin
        own_valid_s = I_req_valid[gidx_q];
        own_last_s  = I_req_last[gidx_q];
        own_data_s  = I_req_data[int'(gidx_q) * BYTE_W +: BYTE_W];
        // The output register can take a byte when empty or draining this cycle.
        out_free_s  = !tx_valid_q || I_tx_ready;
        accept_s    = (state_q == ST_XFER) && own_valid_s && out_free_s;
        req_ready_s = '0;
        if (state_q == ST_XFER) begin
            req_ready_s[gidx_q] = out_free_s;
        end else begin
            req_ready_s = '0;
        end
    end

    // Next-state logic: output register, arbitration FSM, watchdog, counters.
    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        gidx_d     = gidx_q;
        ptr_d      = ptr_q;
        tx_valid_d = tx_valid_q;
        tx_data_d  = tx_data_q;
        abort_d    = 1'b0;
        abort_id_d = abort_id_q;
        msg_cnt_d  = msg_cnt_q;
        to_cnt_d   = to_cnt_q;

        // Output register drains in any state, so an aborted or finished
        // message still delivers the byte it already holds.
        if (accept_s) begin
            tx_valid_d = 1'b1;
            tx_data_d  = own_data_s;
        end else if (tx_valid_q && I_tx_ready) begin
            tx_valid_d = 1'b0;
        end else begin
            tx_valid_d = tx_valid_q;
        end

        case (state_q)
            ST_IDLE: begin
                if (pick_any_s) begin
                    grant_d  = pick_win_s;
                    gidx_d   = pick_idx_s;
                    ptr_d    = pick_idx_s;
                    to_cnt_d = '0;
                    state_d  = ST_XFER;
                end else begin
                    state_d  = ST_IDLE;
                end
            end

            ST_XFER: begin
                if (accept_s && own_last_s) begin
                    msg_cnt_d = msg_cnt_q + CNT_W'(1);
                    grant_d   = '0;
                    to_cnt_d  = '0;
                    state_d   = ST_IDLE;
                end else if (own_valid_s) begin
                    // Owner is alive; stalls caused by the serializer do not count.
                    to_cnt_d  = '0;
                end else if (to_cnt_q == TO_W'(TIMEOUT_CYC - 1)) begin
                    abort_d    = 1'b1;
                    abort_id_d = gidx_q;
                    grant_d    = '0;
                    to_cnt_d   = '0;
                    state_d    = ST_IDLE;
                end else begin
                    to_cnt_d  = to_cnt_q + TO_W'(1);
                end
            end

            default: begin
                state_d  = ST_IDLE;
                grant_d  = '0;
                to_cnt_d = '0;
            end
        endcase
    end

    // State register with asynchronous reset; pointer starts at N_REQ-1 so
    // requester 0 has first priority after reset.
    always_ff @(posedge I_clk or posedge I_rst) begin
        if (I_rst) begin
            state_q    <= ST_IDLE;
            grant_q    <= '0;
            gidx_q     <= '0;
            ptr_q      <= ID_W'(N_REQ - 1);
            tx_valid_q <= 1'b0;
            tx_data_q  <= '0;
            abort_q    <= 1'b0;
            abort_id_q <= '0;
            msg_cnt_q  <= '0;
            to_cnt_q   <= '0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            gidx_q     <= gidx_d;
            ptr_q      <= ptr_d;
            tx_valid_q <= tx_valid_d;
            tx_data_q  <= tx_data_d;
            abort_q    <= abort_d;
            abort_id_q <= abort_id_d;
            msg_cnt_q  <= msg_cnt_d;
            to_cnt_q   <= to_cnt_d;
        end
    end

    assign O_req_ready = req_ready_s;
    assign O_tx_valid  = tx_valid_q;
    assign O_tx_data   = tx_data_q;
    assign O_grant     = grant_q;
    assign O_busy      = (state_q == ST_XFER);
    assign O_abort     = abort_q;
    assign O_abort_id  = abort_id_q;
    assign O_msg_cnt   = msg_cnt_q;

endmodule : uart_print_arbiter

// File: doc/uart_print_arbiter.md
Name: uart_print_arbiter

Overview:
- Shares the board's single UART byte transmitter (`uart_tx` path) among N debug/print requesters, e.g. camera config status, frame counters and FPS telemetry.
- Round-robin arbitration with message locking: a granted requester keeps the UART until its last byte is accepted.
- A stall watchdog aborts a message whose requester goes silent mid-message.
- Sits in the "Print Control" slot of the top level, between the telemetry sources and the UART serializer.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- ID_W, 2, width of the requester index; must equal clog2(N_REQ).
- TIMEOUT_CYC, 2700000, idle cycles allowed mid-message before abort (100 ms at 27 MHz).
- TO_W, 22, width of the timeout counter; must satisfy 2^TO_W > TIMEOUT_CYC.
- CNT_W, 16, width of the completed-message counter.

Ports:
- I_clk, in, 1: system clock; one clock domain only.
- I_rst, in, 1: asynchronous, active-high reset.
- I_req_valid, in, N_REQ: per-requester byte valid.
- I_req_data, in, 8*N_REQ: requester k byte at bits [8k+7:8k].
- I_req_last, in, N_REQ: marks the final byte of a message.
- O_req_ready, out, N_REQ: per-requester byte accept.
- O_tx_valid, out, 1: byte valid toward the UART serializer.
- O_tx_data, out, 8: byte toward the UART serializer.
- I_tx_ready, in, 1: serializer can take a byte.
- O_grant, out, N_REQ: one-hot current owner; all zero in IDLE.
- O_busy, out, 1: high in state XFER.
- O_abort, out, 1: one-cycle pulse on watchdog abort.
- O_abort_id, out, ID_W: index of the aborted requester, held until the next abort.
- O_msg_cnt, out, CNT_W: count of completed messages; wraps modulo 2^CNT_W.

Behaviour:
- Reset (async, active-high): state=IDLE, O_grant=0, O_busy=0, O_tx_valid=0, O_tx_data=0, O_abort=0, O_abort_id=0, O_msg_cnt=0, rr pointer=N_REQ-1, timeout counter=0. Applies immediately, including mid-message; any partially sent message is dropped.
- State IDLE:
  - If any I_req_valid is high, select the first requester with valid high, searching from (ptr+1) mod N_REQ upward with wrap.
  - Register the one-hot grant, set ptr to the winner, go to XFER.
  - No byte is accepted in IDLE.
- State XFER (owner g):
  - O_req_ready[g] = (!O_tx_valid || I_tx_ready), combinational. All other O_req_ready are 0 at all times.
  - Accept = I_req_valid[g] && O_req_ready[g]. On accept: O_tx_data <= byte, O_tx_valid <= 1 on the next edge.
  - If O_tx_valid && I_tx_ready and there is no accept, O_tx_valid <= 0.
  - While O_tx_valid && !I_tx_ready, O_tx_data is held stable.
  - Accept with I_req_last[g]=1: O_msg_cnt += 1, go to IDLE (clear grant). The output register still drains that byte.
- Latency:
  - Request valid at cycle t in IDLE gives grant at t+1 and first accept at t+1 (if the output register is free).
  - O_tx_valid is high at t+2.
  - Sustained throughput is one byte/cycle when I_tx_ready is constantly high.
  - There is exactly one dead cycle (IDLE) between consecutive messages.
- Watchdog:
  - In XFER, the counter increments on each cycle with I_req_valid[g]=0 and clears on any cycle with I_req_valid[g]=1.
  - Downstream back-pressure never advances it.
  - When the counter reaches TIMEOUT_CYC-1 while still incrementing: O_abort pulses, O_abort_id <= g, counter clears, go to IDLE.
  - A byte already in the output register is still delivered; no last byte is synthesized.
  - The counter is cleared on entry to XFER.
- Single-byte message (valid and last together on the first accept) is legal: XFER lasts one cycle.
- Accept-with-last and watchdog expiry cannot coincide, because expiry requires valid=0.
- Requester valid dropping outside XFER ownership has no effect.
- Fairness: a requester continuously requesting waits at most N_REQ-1 messages.
- O_grant is always one-hot or zero.

Decomposition:
- Shared package/include `uart_print_pkg`:
  - state encodings ST_IDLE=1'b0, ST_XFER=1'b1;
  - byte width constant BYTE_W=8;
  - default TIMEOUT_CYC derived from the 27 MHz system clock.
- Sub-module `rr_pick`: combinational round-robin selector. Inputs: request vector and pointer. Outputs: one-hot winner, index, any_req. Fully parameterized by N_REQ.
- The FSM, output register, watchdog and counters stay in `uart_print_arbiter`.

Test Plan:
- Single message: req0 sends 0x48,0x49,0x0A (last on 0x0A), I_tx_ready=1 → grant0 at t+1; O_tx_data 0x48/0x49/0x0A on consecutive cycles from t+2; O_msg_cnt=1; O_grant=0 after.
- Simultaneous request: req1 and req2 valid in the same cycle with ptr=0, 2-byte messages each → req1 is served fully first, then one IDLE cycle, then req2; bytes never interleave.
- Back-pressure: hold I_tx_ready=0 for 5 cycles mid-message → O_tx_data stable, O_req_ready[g]=0, watchdog counter stays 0, no byte lost or duplicated.
- Watchdog: TIMEOUT_CYC=16, req3 sends 1 byte without last, then valid=0 → O_abort pulses exactly 16 cycles later, O_abort_id=3, state returns to IDLE, the byte is still output, O_msg_cnt unchanged.
- Reset mid-message: assert I_rst during byte 2 of 4 → O_tx_valid, O_grant and O_msg_cnt drop to 0 asynchronously; after release, a new request is granted per the rule from ptr=N_REQ-1 (req0 first).
- Wrap and fairness: all 4 requesters continuously request 1-byte messages → grant order 0,1,2,3,0,…; O_msg_cnt wraps from 0xFFFF to 0.
